// File: rtl/regfile_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_alu_sequencer
//  Purpose  : One-command-at-a-time register-file sequencer with built-in ALU;
//             fixed five-cycle read / execute / write-back / respond flow.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_alu_sequencer #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5,
    parameter int SH_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata_a,
    output logic [WIDTH-1:0]  rsp_rdata_b,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [3:0] OP_WRITE = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d, rsp_res_q, rsp_res_d;
    logic              rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]  rf_q [DEPTH];
    logic [WIDTH-1:0]  rf_d [DEPTH];

    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic [WIDTH:0]    alu_sum, alu_diff;
    logic              sh_big;

    // Any set bit above the shift-amount field means a shift of WIDTH or more.
    assign sh_big   = |b_q[WIDTH-1:SH_W];
    assign alu_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign alu_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_WRITE: alu_res = data_q;
            OP_ADD:   begin alu_res = alu_sum[WIDTH-1:0];  alu_carry = alu_sum[WIDTH];  end
            OP_SUB:   begin alu_res = alu_diff[WIDTH-1:0]; alu_carry = alu_diff[WIDTH]; end
            OP_SHL:   alu_res = sh_big ? '0 : (a_q << b_q[SH_W-1:0]);
            OP_SHR:   alu_res = sh_big ? '0 : (a_q >> b_q[SH_W-1:0]);
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rd_d        = rd_q;
        data_d      = data_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        rsp_valid_d = 1'b0;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        rsp_res_d   = rsp_res_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        rf_d        = rf_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    rd_d    = cmd_rd;
                    data_d  = cmd_data;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = rf_q[ra_q];
                b_d     = rf_q[rb_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu_res;
                carry_d = alu_carry;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // Operands were captured two cycles earlier, so rd==ra/rb reports pre-write data.
                if (op_q >= OP_WRITE && op_q <= OP_XOR) begin
                    rf_d[rd_q] = res_q;
                end
                rsp_valid_d = 1'b1;
                rsp_a_d     = a_q;
                rsp_b_d     = b_q;
                rsp_res_d   = res_q;
                rsp_carry_d = carry_q;
                rsp_err_d   = (op_q > OP_XOR);
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_res_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rf_q        <= '{default: '0};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_res_q   <= rsp_res_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            rf_q        <= rf_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = ~cmd_ready;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata_a = rsp_a_q;
    assign rsp_rdata_b = rsp_b_q;
    assign rsp_result  = rsp_res_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_err     = rsp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_alu_sequencer
//  Purpose  : Scoreboard bench: stimulus pushes model responses, monitor pops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_alu_sequencer;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 5;
    localparam int SH_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
    logic [WIDTH-1:0]  cmd_data = '0;
    logic              rsp_valid, rsp_carry, rsp_err, busy;
    logic [WIDTH-1:0]  rsp_rdata_a, rsp_rdata_b, rsp_result;

    regfile_alu_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SH_W(SH_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_rdata_a(rsp_rdata_a), .rsp_rdata_b(rsp_rdata_b),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a, b, res;
        logic             c, e;
        int               acc;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model [32];
    int               cyc = 0;
    int               checks = 0;
    int               passed = 0;
    int               prev_acc = 0;
    bit               last_keep = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour: reads see every earlier write, result written after the read.
    function automatic exp_t predict(input logic [3:0] op, input int ra, input int rb,
                                     input int rd, input logic [WIDTH-1:0] d);
        exp_t e;
        int   a, b;
        a = model[ra];
        b = model[rb];
        e.a = model[ra];
        e.b = model[rb];
        e.c = 0;
        e.e = (op > 10);
        e.acc = 0;
        case (op)
            3:  e.res = d;
            4:  begin e.res = WIDTH'(a + b); e.c = (a + b) > 65535; end
            5:  begin e.res = WIDTH'(a - b); e.c = (a < b); end
            6:  e.res = (b >= WIDTH) ? '0 : WIDTH'(a * (2 ** b));
            7:  e.res = (b >= WIDTH) ? '0 : WIDTH'(a / (2 ** b));
            8:  e.res = e.a & e.b;
            9:  e.res = e.a | e.b;
            10: e.res = e.a ^ e.b;
            default: e.res = '0;
        endcase
        if (op >= 3 && op <= 10) model[rd] = e.res;
        return e;
    endfunction

    // Issue one command starting at a negedge; returns at the negedge after its accept edge.
    task automatic issue(input logic [3:0] op, input int ra, input int rb, input int rd,
                         input logic [WIDTH-1:0] d, input bit keep);
        int   n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ADDR_W'(ra);
        cmd_rb    = ADDR_W'(rb);
        cmd_rd    = ADDR_W'(rd);
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e = predict(op, ra, rb, rd, d);
        e.acc = cyc + 1;
        if (last_keep) chk("b2b_spacing", e.acc - prev_acc, 5);
        prev_acc  = e.acc;
        last_keep = keep;
        sb.push_back(e);
        @(negedge clk);
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_op    = 4'($urandom);
            cmd_ra    = ADDR_W'($urandom);
            cmd_rb    = ADDR_W'($urandom);
            cmd_rd    = ADDR_W'($urandom);
            cmd_data  = WIDTH'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_latency", cyc - e.acc, 3);
                chk("rsp_rdata_a", rsp_rdata_a, e.a);
                chk("rsp_rdata_b", rsp_rdata_b, e.b);
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_carry", rsp_carry, e.c);
                chk("rsp_err", rsp_err, e.e);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_fields"}, {rsp_rdata_a, rsp_rdata_b, rsp_result, rsp_carry, rsp_err}, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'd2, 0, 31, 0, '0, 0);
        issue(4'd3, 0, 0, 5, 16'h1234, 1);
        issue(4'd1, 5, 0, 0, '0, 0);
        issue(4'd3, 0, 0, 1, 16'hFFFF, 1);
        issue(4'd3, 0, 0, 2, 16'h0001, 1);
        issue(4'd4, 1, 2, 3, '0, 1);
        issue(4'd3, 0, 0, 4, 16'h0003, 1);
        issue(4'd3, 0, 0, 5, 16'h0005, 1);
        issue(4'd5, 4, 5, 6, '0, 1);
        issue(4'd3, 0, 0, 7, 16'h00F0, 1);
        issue(4'd3, 0, 0, 8, 16'h0004, 1);
        issue(4'd3, 0, 0, 9, 16'h0010, 1);
        issue(4'd3, 0, 0, 10, 16'h00FF, 1);
        issue(4'd6, 7, 8, 11, '0, 1);
        issue(4'd7, 7, 8, 12, '0, 1);
        issue(4'd6, 7, 9, 13, '0, 1);
        issue(4'd10, 12, 10, 14, '0, 0);
        issue(4'd3, 0, 0, 1, 16'h0003, 0);
        issue(4'd4, 1, 1, 1, '0, 0);
        issue(4'd1, 1, 0, 0, '0, 0);
        issue(4'd12, 1, 2, 1, 16'hBEEF, 0);
        issue(4'd2, 1, 2, 0, '0, 0);
        wait_drain();

        // Reset while a write is in flight: it must never land or respond.
        issue(4'd3, 0, 0, 2, 16'hAAAA, 0);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (4) @(negedge clk);
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);
        issue(4'd1, 2, 0, 0, '0, 0);
        wait_drain();

        for (int i = 0; i < 120; i++) begin
            logic [WIDTH-1:0] d;
            d = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 20)) : WIDTH'($urandom);
            issue(4'($urandom_range(0, 15)), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), d, (i != 119) && $urandom_range(0, 1) == 1);
        end
        wait_drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
